// File: rtl/reg_fifo_pkg.sv
// Shared sizing for reg_fifo: default word/depth and pointer/count width derivation.
// Count is one bit wider than the pointer so that "full" (count == DEPTH) is representable.
package reg_fifo_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 8;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return ptr_w(depth) + 1;
    endfunction

endpackage

// File: rtl/reg_fifo_ptr.sv
// fifo_ptr: wrapping pointer, advances by one when en is high; 1-cycle update, no backpressure.
// Wrap from DEPTH-1 to 0 comes from natural overflow because DEPTH is a power of two.
module fifo_ptr #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] ptr
);

    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (en) ptr_d = ptr_q + W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/reg_fifo.sv
// reg_fifo: show-ahead flop FIFO, zero-latency read, pushed word visible next cycle; optional sticky ovf/unf via REG_FIFO_ERR_EN.
// Backpressure: wr_ready drops when full or while in reset; rd_valid drops when empty.
module reg_fifo
    import reg_fifo_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int DEPTH = DEF_DEPTH,
    localparam int PW    = ptr_w(DEPTH),
    localparam int CW    = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [CW-1:0]    count,
    output logic             ovf,
    output logic             unf,
    input  logic             err_clr
);

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    // rst_n gates wr_ready so upstream never sees a ready FIFO while it is being cleared
    assign wr_ready = rst_n & ~full;
    assign rd_valid = ~empty;
    assign push     = wr_valid & wr_ready;
    assign pop      = rd_valid & rd_ready;
    assign rd_data  = mem_q[rd_ptr];
    assign count    = count_q;

    fifo_ptr #(.W(PW)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (push),
        .ptr   (wr_ptr)
    );

    fifo_ptr #(.W(PW)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pop),
        .ptr   (rd_ptr)
    );

    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_ptr] = wr_data;
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

`ifdef REG_FIFO_ERR_EN
    logic ovf_q;
    logic ovf_d;
    logic unf_q;
    logic unf_d;

    // A new error on the same edge as err_clr must survive the clear
    always_comb begin
        ovf_d = (ovf_q & ~err_clr) | (wr_valid & full);
        unf_d = (unf_q & ~err_clr) | (rd_ready & empty);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign ovf = ovf_q;
    assign unf = unf_q;
`else
    logic err_clr_unused;

    assign err_clr_unused = err_clr;
    assign ovf            = 1'b0;
    assign unf            = 1'b0;
`endif

endmodule

// File: doc/reg_fifo.md
REG_FIFO -- requirements
Module: reg_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, number of entries; power of two, at least 2.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port wr_data, input, WIDTH, word from the upstream 32-bit register stage.
REQ-006 SHALL have port wr_valid, input, 1, upstream offers wr_data this cycle.
REQ-007 SHALL have port wr_ready, output, 1, FIFO accepts a word this cycle.
REQ-008 SHALL have port rd_data, output, WIDTH, oldest stored word (show-ahead).
REQ-009 SHALL have port rd_valid, output, 1, rd_data holds a valid word.
REQ-010 SHALL have port rd_ready, input, 1, downstream consumes rd_data this cycle.
REQ-011 SHALL have port count, output, log2(DEPTH)+1, number of stored words.
REQ-012 SHALL have ports ovf and unf, output, 1 each, sticky overflow/underflow flags.
REQ-013 SHALL have port err_clr, input, 1, clears ovf and unf.

Function
REQ-014 Push SHALL occur on a rising edge when wr_valid and wr_ready are both 1; pop SHALL occur when rd_valid and rd_ready are both 1.
REQ-015 wr_ready SHALL equal (count != DEPTH); rd_valid SHALL equal (count != 0); both combinational from registered state.
REQ-016 rd_data SHALL be the entry at the read pointer with zero-cycle latency; a pushed word SHALL appear on rd_data one cycle after push when the FIFO was empty.
REQ-017 Write and read pointers SHALL be log2(DEPTH) bits and wrap from DEPTH-1 to 0 with no gap.
REQ-018 count SHALL increment on push-only, decrement on pop-only, and hold on simultaneous push and pop or on neither.
REQ-019 Simultaneous push and pop SHALL be permitted at any non-full, non-empty level, and also when empty+push-only or full+pop-only apply; ordering SHALL be strictly first-in first-out.
REQ-020 wr_valid while full SHALL store nothing and leave pointers and count unchanged; rd_ready while empty SHALL change nothing.
REQ-021 wr_data SHALL be captured unmodified; no arithmetic on data.

Reset
REQ-022 rst_n low SHALL immediately clear pointers, count, ovf, unf and all storage entries to 0, independent of clk.
REQ-023 During reset: wr_ready=0... SHALL be 1 only after rst_n deasserts; rd_valid=0, rd_data=0, count=0.
REQ-024 Reset asserted mid-transfer SHALL discard all stored words; the first edge after release SHALL behave as empty FIFO.

Configuration
REQ-025 Macro REG_FIFO_ERR_EN defined: ovf SHALL set on any edge with wr_valid=1 and count=DEPTH; unf SHALL set on any edge with rd_ready=1 and count=0; both held until err_clr=1 at an edge (set wins if simultaneous with clear).
REQ-026 Macro REG_FIFO_ERR_EN undefined: ovf and unf SHALL be constant 0, err_clr ignored, no flag flops synthesised.

Structure
REQ-027 Package reg_fifo_pkg SHALL hold default WIDTH/DEPTH constants and the pointer/count width derivation.
REQ-028 One sub-module fifo_ptr (wrapping pointer with enable, async active-low clear) SHALL be instantiated for the read and write pointers.
REQ-029 Storage SHALL be a flop array of DEPTH x WIDTH; no RAM macro.

Verification
REQ-030 Reset then push 0,6,12 on three edges -> count=3, rd_data=0, rd_valid=1, wr_ready=1.
REQ-031 Push 8 words 6,12..48 with rd_ready=0 -> count=8, wr_ready=0; 9th push 54 dropped, ovf=1 (with REG_FIFO_ERR_EN), pops return 6..48 in order.
REQ-032 Empty FIFO, rd_ready=1 for 2 cycles -> count stays 0, rd_valid=0, unf=1 (with macro), 0 without; err_clr pulse -> unf=0.
REQ-033 Hold count=4, push and pop every cycle for 18 cycles (d+=6 stimulus) -> count stays 4, pointers wrap twice, output sequence equals input delayed 4 transfers.
REQ-034 Full FIFO, wr_valid=1 and rd_ready=1 same edge -> one pop only, count=7, next edge push accepted, count=8.
REQ-035 Assert rst_n low mid-burst between edges at count=5 -> count, rd_valid, rd_data go 0 immediately; after release push 30 -> rd_data=30 next cycle.
